// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared types and widths for the fetch/data memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    localparam int c_ADDR_W = 30;
    localparam int c_DATA_W = 32;
    localparam int c_BE_W   = 4;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        IF   = 2'd1,
        DM   = 2'd2
    } owner_e;

endpackage : mem_arb_pkg

`default_nettype wire

// File: rtl/mem_arb_starve_guard.sv
// ============================================================================
// Module   : mem_arb_starve_guard
// Purpose  : Counts consecutive denied fetch cycles; fires at STARVE_LIMIT.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb_starve_guard
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_run,
    input  logic i_if_req,
    input  logic i_if_gnt,
    output logic o_fire
);

    localparam logic [3:0] c_LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] r_starve_cnt;

    // Saturates at the limit so the fire cycle is held until fetch is served.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= 4'd0;
        end else if (!i_run || !i_if_req || i_if_gnt) begin
            r_starve_cnt <= 4'd0;
        end else if (r_starve_cnt != c_LIMIT) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

    assign o_fire = i_run & (r_starve_cnt == c_LIMIT);

endmodule : mem_arb_starve_guard

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Arbitrates fetch and data ports onto one single-port memory.
//            Optional macro MEM_ARBITER_STARVE_GUARD_EN enables fetch guard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [c_ADDR_W-1:0] if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [c_DATA_W-1:0] if_rdata,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [c_BE_W-1:0]   dm_be,
    input  logic [c_ADDR_W-1:0] dm_addr,
    input  logic [c_DATA_W-1:0] dm_wdata,
    output logic                dm_gnt,
    output logic                dm_rvalid,
    output logic [c_DATA_W-1:0] dm_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [c_BE_W-1:0]   mem_be,
    output logic [c_ADDR_W-1:0] mem_addr,
    output logic [c_DATA_W-1:0] mem_wdata,
    input  logic [c_DATA_W-1:0] mem_rdata,
    input  logic                ebreak,
    input  logic                resume
);

    state_e r_state;
    owner_e r_owner;
    logic   w_run;
    logic   w_fire;
    logic   w_if_gnt;
    logic   w_dm_gnt;

    assign w_run = (r_state == RUN);

`ifdef MEM_ARBITER_STARVE_GUARD_EN
    mem_arb_starve_guard #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_guard (
        .clk      (clk),
        .rst      (reset),
        .i_run    (w_run),
        .i_if_req (if_req),
        .i_if_gnt (w_if_gnt),
        .o_fire   (w_fire)
    );
`else
    assign w_fire = 1'b0;
`endif

    // Reset gates the grants so nothing reaches memory while reset is held.
    always_comb begin
        w_if_gnt = 1'b0;
        w_dm_gnt = 1'b0;
        if (!reset) begin
            if (if_req && w_run && (w_fire || !dm_req)) begin
                w_if_gnt = 1'b1;
            end else if (dm_req) begin
                w_dm_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_if_gnt) begin
            mem_be   = 4'hF;
            mem_addr = if_addr;
        end else if (w_dm_gnt) begin
            mem_we    = dm_we;
            mem_be    = dm_be;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RUN;
            r_owner <= NONE;
        end else begin
            case (r_state)
                RUN:     if (ebreak) r_state <= HALTED;
                HALTED:  if (resume && !ebreak) r_state <= RUN;
                default: r_state <= RUN;
            endcase
            if (w_if_gnt) begin
                r_owner <= IF;
            end else if (w_dm_gnt && !dm_we) begin
                r_owner <= DM;
            end else begin
                r_owner <= NONE;
            end
        end
    end

    assign if_gnt    = w_if_gnt;
    assign dm_gnt    = w_dm_gnt;
    assign mem_en    = w_if_gnt | w_dm_gnt;
    assign if_rvalid = (r_owner == IF);
    assign dm_rvalid = (r_owner == DM);
    assign if_rdata  = mem_rdata;
    assign dm_rdata  = mem_rdata;

endmodule : mem_arbiter

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed self-checking bench for mem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

`ifdef MEM_ARBITER_STARVE_GUARD_EN
    localparam bit c_GUARD = 1'b1;
`else
    localparam bit c_GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0, if_gnt, if_rvalid;
    logic [29:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        dm_req = 1'b0, dm_we = 1'b0, dm_gnt, dm_rvalid;
    logic [3:0]  dm_be = '0;
    logic [29:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0, dm_rdata;
    logic        mem_en, mem_we;
    logic [3:0]  mem_be;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        ebreak = 1'b0, resume = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Memory: registered read data = address xor a fixed tag.
    always @(posedge clk) begin
        if (mem_en && !mem_we) mem_rdata <= 32'hA5A5_0000 ^ {2'b00, mem_addr};
    end

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .ebreak(ebreak), .resume(resume)
    );

    task automatic drive_idle();
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_be = '0; dm_addr = '0; dm_wdata = '0;
        ebreak = 1'b0; resume = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; if_req = 1'b1; dm_req = 1'b1; dm_addr = 30'h55; dm_wdata = 32'h1234;
        #1;
        checks++; if (if_gnt !== 1'b0) begin errors++; $display("FAIL rst_if_gnt got %b exp 0", if_gnt); end
        checks++; if (dm_gnt !== 1'b0) begin errors++; $display("FAIL rst_dm_gnt got %b exp 0", dm_gnt); end
        checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL rst_mem_en got %b exp 0", mem_en); end
        checks++; if (mem_addr !== 30'h0) begin errors++; $display("FAIL rst_mem_addr got %h exp 0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_wdata got %h exp 0", mem_wdata); end
        checks++; if ({if_rvalid, dm_rvalid} !== 2'b00) begin errors++; $display("FAIL rst_rvalid got %b exp 00", {if_rvalid, dm_rvalid}); end
        @(negedge clk); drive_idle(); reset = 1'b0;
        @(posedge clk); #1;
        checks++; if ({if_rvalid, dm_rvalid} !== 2'b00) begin errors++; $display("FAIL rst_release_rvalid got %b exp 00", {if_rvalid, dm_rvalid}); end
    endtask

    task automatic test_fetch();
        @(negedge clk); if_req = 1'b1; if_addr = 30'h10;
        #1;
        checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL fetch_if_gnt got %b exp 1", if_gnt); end
        checks++; if (dm_gnt !== 1'b0) begin errors++; $display("FAIL fetch_dm_gnt got %b exp 0", dm_gnt); end
        checks++; if (mem_addr !== 30'h10) begin errors++; $display("FAIL fetch_mem_addr got %h exp 10", mem_addr); end
        checks++; if ({mem_en, mem_we, mem_be} !== 6'b10_1111) begin errors++; $display("FAIL fetch_mem_ctl got %b exp 101111", {mem_en, mem_we, mem_be}); end
        @(posedge clk); #1;
        checks++; if ({if_rvalid, dm_rvalid} !== 2'b10) begin errors++; $display("FAIL fetch_rvalid got %b exp 10", {if_rvalid, dm_rvalid}); end
        checks++; if (if_rdata !== 32'hA5A5_0010) begin errors++; $display("FAIL fetch_rdata got %h exp a5a50010", if_rdata); end
        @(negedge clk); drive_idle();
        @(posedge clk); #1;
    endtask

    task automatic test_priority();
        @(negedge clk); if_req = 1'b1; if_addr = 30'h3; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 30'h40;
        #1;
        checks++; if ({if_gnt, dm_gnt} !== 2'b01) begin errors++; $display("FAIL prio_gnt got %b exp 01", {if_gnt, dm_gnt}); end
        checks++; if (mem_addr !== 30'h40) begin errors++; $display("FAIL prio_mem_addr got %h exp 40", mem_addr); end
        @(posedge clk); #1;
        checks++; if ({if_rvalid, dm_rvalid} !== 2'b01) begin errors++; $display("FAIL prio_rvalid got %b exp 01", {if_rvalid, dm_rvalid}); end
        checks++; if (dm_rdata !== 32'hA5A5_0040) begin errors++; $display("FAIL prio_rdata got %h exp a5a50040", dm_rdata); end
        @(negedge clk); drive_idle();
        @(posedge clk); #1;
    endtask

    task automatic test_store();
        @(negedge clk); dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'b0011; dm_addr = 30'h20; dm_wdata = 32'hDEADBEEF;
        #1;
        checks++; if (dm_gnt !== 1'b1) begin errors++; $display("FAIL store_gnt got %b exp 1", dm_gnt); end
        checks++; if ({mem_en, mem_we, mem_be} !== 6'b11_0011) begin errors++; $display("FAIL store_mem_ctl got %b exp 110011", {mem_en, mem_we, mem_be}); end
        checks++; if (mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL store_wdata got %h exp deadbeef", mem_wdata); end
        checks++; if (mem_addr !== 30'h20) begin errors++; $display("FAIL store_addr got %h exp 20", mem_addr); end
        @(negedge clk); drive_idle();
        #1;
        checks++; if ({if_rvalid, dm_rvalid} !== 2'b00) begin errors++; $display("FAIL store_rvalid got %b exp 00", {if_rvalid, dm_rvalid}); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        @(negedge clk); if_req = 1'b1; if_addr = 30'h1;
        @(negedge clk); if_req = 1'b0; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 30'h2;
        #1;
        checks++; if ({if_rvalid, dm_gnt} !== 2'b11) begin errors++; $display("FAIL b2b_first got %b exp 11", {if_rvalid, dm_gnt}); end
        checks++; if (if_rdata !== 32'hA5A5_0001) begin errors++; $display("FAIL b2b_if_rdata got %h exp a5a50001", if_rdata); end
        @(posedge clk); #1;
        checks++; if ({if_rvalid, dm_rvalid} !== 2'b01) begin errors++; $display("FAIL b2b_rvalid got %b exp 01", {if_rvalid, dm_rvalid}); end
        checks++; if (dm_rdata !== 32'hA5A5_0002) begin errors++; $display("FAIL b2b_dm_rdata got %h exp a5a50002", dm_rdata); end
        @(negedge clk); drive_idle();
        @(posedge clk); #1;
    endtask

    task automatic test_starve();
        logic exp_if;
        @(negedge clk); if_req = 1'b1; if_addr = 30'h7; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 30'h9;
        for (int k = 0; k < 8; k++) begin
            #1;
            exp_if = c_GUARD && (k == 4);
            checks++;
            if ({if_gnt, dm_gnt} !== {exp_if, ~exp_if}) begin
                errors++; $display("FAIL starve_cyc%0d got %b exp %b", k, {if_gnt, dm_gnt}, {exp_if, ~exp_if});
            end
            @(negedge clk);
        end
        drive_idle();
        @(posedge clk); #1;
    endtask

    task automatic test_halt();
        @(negedge clk); if_req = 1'b1; if_addr = 30'h8; ebreak = 1'b1;
        #1;
        checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL halt_fetch_gnt got %b exp 1", if_gnt); end
        @(posedge clk); #1;
        checks++; if ({if_rvalid, if_rdata} !== {1'b1, 32'hA5A5_0008}) begin errors++; $display("FAIL halt_outstanding got %b/%h exp 1/a5a50008", if_rvalid, if_rdata); end
        @(negedge clk); ebreak = 1'b0; dm_req = 1'b1; dm_addr = 30'h44;
        #1;
        checks++; if ({if_gnt, dm_gnt} !== 2'b01) begin errors++; $display("FAIL halt_dm_gnt got %b exp 01", {if_gnt, dm_gnt}); end
        @(posedge clk); #1;
        checks++; if (dm_rvalid !== 1'b1) begin errors++; $display("FAIL halt_dm_rvalid got %b exp 1", dm_rvalid); end
        @(negedge clk); dm_req = 1'b0; resume = 1'b1;
        #1;
        checks++; if (if_gnt !== 1'b0) begin errors++; $display("FAIL halt_resume_cycle got %b exp 0", if_gnt); end
        @(negedge clk); resume = 1'b0;
        #1;
        checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL halt_after_resume got %b exp 1", if_gnt); end
        @(negedge clk); ebreak = 1'b1; resume = 1'b1;
        @(negedge clk); ebreak = 1'b0; resume = 1'b0;
        #1;
        checks++; if (if_gnt !== 1'b0) begin errors++; $display("FAIL halt_both_stay got %b exp 0", if_gnt); end
        @(negedge clk); resume = 1'b1;
        @(negedge clk); drive_idle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset_outstanding();
        @(negedge clk); if_req = 1'b1; if_addr = 30'h10;
        #1;
        checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL rout_gnt got %b exp 1", if_gnt); end
        #2; reset = 1'b1;
        #1;
        checks++; if ({if_gnt, mem_en, mem_be} !== 6'b0) begin errors++; $display("FAIL rout_outputs got %b exp 0", {if_gnt, mem_en, mem_be}); end
        @(posedge clk); #1;
        checks++; if ({if_rvalid, dm_rvalid} !== 2'b00) begin errors++; $display("FAIL rout_rvalid got %b exp 00", {if_rvalid, dm_rvalid}); end
        @(negedge clk); drive_idle(); reset = 1'b0;
        @(posedge clk); #1;
        checks++; if ({if_rvalid, dm_rvalid} !== 2'b00) begin errors++; $display("FAIL rout_release got %b exp 00", {if_rvalid, dm_rvalid}); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_priority();
        test_store();
        test_back_to_back();
        test_starve();
        test_halt();
        test_reset_outstanding();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mem_arbiter

`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, consecutive denied fetch cycles before the starvation guard fires (range 1..15).
REQ-002 clk  in  1  system clock; all state updates on posedge clk.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 if_req  in  1  fetch read request.
REQ-005 if_addr  in  30  fetch word address [31:2].
REQ-006 if_gnt  out  1  fetch request accepted this cycle.
REQ-007 if_rvalid  out  1  fetch read data valid.
REQ-008 if_rdata  out  32  fetch read data.
REQ-009 dm_req  in  1  data request (load or store).
REQ-010 dm_we  in  1  1 = store, 0 = load.
REQ-011 dm_be  in  4  store byte enables.
REQ-012 dm_addr  in  30  data word address [31:2].
REQ-013 dm_wdata  in  32  store data.
REQ-014 dm_gnt  out  1  data request accepted this cycle.
REQ-015 dm_rvalid  out  1  load data valid.
REQ-016 dm_rdata  out  32  load data.
REQ-017 mem_en, mem_we  out  1 each  shared single-port memory enable and write strobe.
REQ-018 mem_be  out  4; mem_addr  out  30; mem_wdata  out  32  shared memory controls.
REQ-019 mem_rdata  in  32  memory read data, registered inside memory, valid one cycle after a read enable.
REQ-020 ebreak  in  1  halt request; resume  in  1  single-cycle restart pulse.

Function
REQ-021 Grants SHALL be combinational in the request cycle; at most one of if_gnt/dm_gnt high per cycle.
REQ-022 Default priority: dm_req wins; if_gnt = if_req & !dm_req & state==RUN.
REQ-023 mem_en = if_gnt | dm_gnt; mem_addr/mem_we/mem_be/mem_wdata SHALL come from the granted requester; fetch grant drives mem_we=0, mem_be=4'hF; no grant drives all zero.
REQ-024 Owner register SHALL record the granted read (IF, DM, NONE); stores record NONE.
REQ-025 Exactly one cycle after a granted read, the owner's rvalid SHALL be 1 for one cycle; the other rvalid SHALL be 0.
REQ-026 if_rdata and dm_rdata SHALL both equal mem_rdata unconditionally; consumers qualify with rvalid.
REQ-027 Back-to-back grants allowed every cycle; throughput one access per cycle.
REQ-028 FSM states RUN, HALTED: RUN->HALTED on posedge clk with ebreak=1; HALTED->RUN on resume=1; ebreak and resume together SHALL stay/enter HALTED.
REQ-029 In HALTED, if_gnt = 0; data grants continue; a fetch response already outstanding SHALL still be delivered.
REQ-030 starve_cnt (4 bits) SHALL increment, saturating at STARVE_LIMIT, when state==RUN & if_req & !if_gnt; it SHALL clear on if_gnt, on !if_req, and in HALTED.

Reset
REQ-031 While reset=1: state=RUN, owner=NONE, starve_cnt=0, all outputs 0 (rdata outputs follow mem_rdata).
REQ-032 Reset asserted with a read outstanding SHALL discard its rvalid; no rvalid in the first cycle after reset release.

Configuration
REQ-033 Macro MEM_ARBITER_STARVE_GUARD_EN defined: when starve_cnt==STARVE_LIMIT in RUN, fetch SHALL win over dm_req for that one cycle (dm_gnt=0), then counter clears.
REQ-034 Macro undefined: starve_cnt logic absent; strict data priority always.

Structure
REQ-035 Shared package mem_arb_pkg SHALL hold the state enum (RUN, HALTED), owner enum (NONE, IF, DM), and memory width constants (address 30, data 32).
REQ-036 Sub-module mem_arb_starve_guard SHALL contain the counter and fire output; instantiated only under the macro.

Verification
REQ-037 if_req=1 only, if_addr=0x10 -> if_gnt=1, mem_addr=0x10, mem_we=0; next cycle if_rvalid=1, if_rdata=mem_rdata.
REQ-038 if_req=dm_req=1, dm_we=0, dm_addr=0x40 -> dm_gnt=1, if_gnt=0; next cycle dm_rvalid=1, if_rvalid=0.
REQ-039 dm store (dm_we=1, dm_be=4'b0011, wdata=0xDEADBEEF) -> mem_we=1, mem_be=0011, wdata passed; no rvalid next cycle.
REQ-040 Macro on, STARVE_LIMIT=4, if_req and dm_req held high -> dm granted 4 cycles, if_gnt on 5th cycle, then dm again; macro off -> if_gnt never.
REQ-041 Fetch granted, ebreak=1 same cycle -> if_rvalid still next cycle; if_gnt=0 until resume pulse; dm grants continue.
REQ-042 Read granted, reset pulsed next edge -> no rvalid; all outputs 0 during reset.
